// File: rtl/adder_tree_sequencer.sv
// ---------------------------------------------------------------------------
// adder_tree_sequencer
//   Feeds a long int8 vector into a free-running pipelined adder tree. The
//   vector arrives as cfg_chunks beats of ELEMENTS lanes. The block
//   accumulates the tree results into one wrapped 8-bit sum and offers that
//   sum on a ready/valid output.
//
// Ports
//   clk_in, rst_n_in      clock, asynchronous active-low reset
//   start, cfg_chunks     job request (sampled in IDLE only) and beat count
//   busy                  high whenever the sequencer is not IDLE
//   in_valid/in_ready     beat handshake; in_ready is high only in FEED
//   in_data               beat lanes, packed [ELEMENTS-1:0][7:0]
//   tree_in               registered drive into the adder tree (0 on bubbles)
//   tree_out              signed tree result, TREE_LATENCY edges after tree_in
//   out_valid/out_ready   sum handshake; out_valid is high only in DONE
//   out_sum               signed running sum, modulo 256
// ---------------------------------------------------------------------------
module adder_tree_sequencer #(
    parameter  int unsigned ELEMENTS     = 12,
    parameter  int unsigned TREE_LATENCY = 4,
    parameter  int unsigned MAX_CHUNKS   = 16,
    localparam int unsigned CW           = $clog2(MAX_CHUNKS + 1),
    localparam int unsigned DW           = ELEMENTS * 8
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          start,
    input  logic [CW-1:0] cfg_chunks,
    output logic          busy,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] tree_in,
    input  logic [7:0]    tree_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_sum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           chunks_q, chunks_d;
    logic [CW-1:0]           accepted_q, accepted_d;
    logic [CW-1:0]           retired_q, retired_d;
    logic [TREE_LATENCY-1:0] vsr_q, vsr_d;
    logic [7:0]              acc_q, acc_d;
    logic [DW-1:0]           tree_in_q, tree_in_d;
    logic                    busy_q, busy_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [7:0]              out_sum_q, out_sum_d;

    logic                    accept_c;
    logic                    retire_c;

    // A beat is taken whenever the registered ready meets a valid beat.
    assign accept_c = in_valid && in_ready_q;

    // The oldest vsr bit marks the beat whose tree result is on tree_out now.
    assign retire_c = vsr_q[TREE_LATENCY-1] &&
                      ((state_q == S_FEED) || (state_q == S_DRAIN));

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d     = state_q;
        chunks_d    = chunks_q;
        accepted_d  = accepted_q;
        retired_d   = retired_q;
        acc_d       = acc_q;
        tree_in_d   = '0;
        vsr_d       = TREE_LATENCY'({vsr_q, accept_c});
        busy_d      = 1'b0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        out_sum_d   = 8'd0;

        // Bubbles drive zero so the tree keeps running without stalling.
        if (accept_c) begin
            tree_in_d  = in_data;
            accepted_d = accepted_q + CW'(1);
        end

        if (retire_c) begin
            retired_d = retired_q + CW'(1);
            acc_d     = acc_q + tree_out;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    chunks_d   = cfg_chunks;
                    accepted_d = '0;
                    retired_d  = '0;
                    acc_d      = 8'd0;
                    state_d    = (cfg_chunks == '0) ? S_DONE : S_FEED;
                end
            end
            S_FEED: begin
                if (accept_c && ((accepted_q + CW'(1)) == chunks_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The last retire has already been counted on the prior edge.
                if (retired_q == chunks_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d      = (state_d != S_IDLE);
        in_ready_d  = (state_d == S_FEED);
        out_valid_d = (state_d == S_DONE);
        out_sum_d   = acc_d;
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= S_IDLE;
            chunks_q    <= '0;
            accepted_q  <= '0;
            retired_q   <= '0;
            vsr_q       <= '0;
            acc_q       <= 8'd0;
            tree_in_q   <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            chunks_q    <= chunks_d;
            accepted_q  <= accepted_d;
            retired_q   <= retired_d;
            vsr_q       <= vsr_d;
            acc_q       <= acc_d;
            tree_in_q   <= tree_in_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
        end
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign tree_in   = tree_in_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_adder_tree_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adder_tree_sequencer
//   Directed bench: ELEMENTS=4, TREE_LATENCY=2, with a behavioural tree whose
//   result for a tree_in value is seen by the sequencer two edges later.
// ---------------------------------------------------------------------------
module tb_adder_tree_sequencer;

    localparam int unsigned ELEMENTS     = 4;
    localparam int unsigned TREE_LATENCY = 2;
    localparam int unsigned MAX_CHUNKS   = 16;
    localparam int unsigned CW           = $clog2(MAX_CHUNKS + 1);
    localparam int unsigned DW           = ELEMENTS * 8;

    logic          clk_in;
    logic          rst_n_in;
    logic          start;
    logic [CW-1:0] cfg_chunks;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [DW-1:0] tree_in;
    logic [7:0]    tree_out;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_sum;

    int errors = 0;
    int checks = 0;

    adder_tree_sequencer #(
        .ELEMENTS    (ELEMENTS),
        .TREE_LATENCY(TREE_LATENCY),
        .MAX_CHUNKS  (MAX_CHUNKS)
    ) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .start     (start),
        .cfg_chunks(cfg_chunks),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .tree_in   (tree_in),
        .tree_out  (tree_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Behavioural tree: wrapped lane sum plus TREE_LATENCY-1 register stages.
    logic [7:0] lane_sum;
    logic [7:0] tree_stage_q;

    always_comb begin
        lane_sum = 8'd0;
        for (int i = 0; i < int'(ELEMENTS); i++) begin
            lane_sum = lane_sum + tree_in[i*8 +: 8];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) tree_stage_q <= 8'd0;
        else           tree_stage_q <= lane_sum;
    end

    assign tree_out = tree_stage_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic start_job(input int n);
        start      = 1'b1;
        cfg_chunks = CW'(n);
        tick();
        start      = 1'b0;
        cfg_chunks = CW'(7);
    endtask

    // Presents n beats back to back with in_valid held high.
    task automatic feed(input int n, input logic [31:0] data);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = data;
            check_eq("in_ready_feed", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Counts cycles from the last accept until out_valid, bounded.
    task automatic wait_done(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(n), 32'(exp_cycles));
    endtask

    task automatic release_sum();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("idle_out_valid", 32'(out_valid), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n_in   = 1'b0;
        start      = 1'b0;
        cfg_chunks = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_sum", 32'(out_sum), 32'd0);
        check_eq("rst_tree_in", tree_in, 32'd0);
        #2 rst_n_in = 1'b1;
        tick();

        // 3 beats of lanes 1: 3 * 4 = 12.
        start_job(3);
        check_eq("t1_busy", 32'(busy), 32'd1);
        feed(3, 32'h0101_0101);
        check_eq("t1_in_ready_low", 32'(in_ready), 32'd0);
        wait_done("t1_latency", 3);
        check_eq("t1_sum", 32'(out_sum), 32'd12);
        release_sum();

        // 100 then -20 with a 3-cycle gap -> 80.
        start_job(2);
        feed(1, 32'h281E_140A);
        check_eq("t2_tree_in_beat", tree_in, 32'h281E_140A);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t2_gap_tree_in", tree_in, 32'd0);
            check_eq("t2_gap_in_ready", 32'(in_ready), 32'd1);
            check_eq("t2_gap_out_valid", 32'(out_valid), 32'd0);
        end
        check_eq("t2_gap_acc", 32'(out_sum), 32'd100);
        feed(1, 32'hFBFB_FBFB);
        wait_done("t2_latency", 3);
        check_eq("t2_sum", 32'(out_sum), 32'd80);
        release_sum();

        // 4 beats of lanes 32: 512 mod 256 = 0.
        start_job(4);
        feed(4, 32'h2020_2020);
        wait_done("t3_latency", 3);
        check_eq("t3_sum_wrap", 32'(out_sum), 32'd0);
        release_sum();

        // 1 beat of lanes 127: tree wraps 508 -> 0xFC.
        start_job(1);
        feed(1, 32'h7F7F_7F7F);
        wait_done("t3b_latency", 3);
        check_eq("t3b_sum_neg", 32'(out_sum), 32'hFC);
        release_sum();

        // Zero chunks: DONE right after the start edge; hold under back-pressure.
        start_job(0);
        check_eq("t4_out_valid", 32'(out_valid), 32'd1);
        check_eq("t4_sum_zero", 32'(out_sum), 32'd0);
        check_eq("t4_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            start      = 1'b1;
            cfg_chunks = CW'(3);
            tick();
            check_eq("t4_hold_valid", 32'(out_valid), 32'd1);
            check_eq("t4_hold_sum", 32'(out_sum), 32'd0);
            check_eq("t4_hold_in_ready", 32'(in_ready), 32'd0);
        end
        start = 1'b0;
        release_sum();

        // Abort during DRAIN after the first beat has retired.
        start_job(2);
        feed(2, 32'h0101_0101);
        tick();
        check_eq("t5_pre_abort_sum", 32'(out_sum), 32'd4);
        check_eq("t5_pre_abort_busy", 32'(busy), 32'd1);
        #2 rst_n_in = 1'b0;
        #1;
        check_eq("t5_abort_busy", 32'(busy), 32'd0);
        check_eq("t5_abort_sum", 32'(out_sum), 32'd0);
        check_eq("t5_abort_valid", 32'(out_valid), 32'd0);
        check_eq("t5_abort_tree_in", tree_in, 32'd0);
        #2 rst_n_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("t5_no_late_valid", 32'(out_valid), 32'd0);
        end
        start_job(1);
        feed(1, 32'h0202_0202);
        wait_done("t5_latency", 3);
        check_eq("t5_sum", 32'(out_sum), 32'd8);
        release_sum();

        // Back-to-back jobs: start the cycle after returning to IDLE.
        start_job(1);
        feed(1, 32'h0303_0303);
        wait_done("t6a_latency", 3);
        check_eq("t6a_sum", 32'(out_sum), 32'd12);
        release_sum();
        start_job(2);
        check_eq("t6b_busy", 32'(busy), 32'd1);
        check_eq("t6b_cleared", 32'(out_sum), 32'd0);
        feed(2, 32'h0403_0201);
        wait_done("t6b_latency", 3);
        check_eq("t6b_sum", 32'(out_sum), 32'd20);
        release_sum();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
